// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential ALU divider.
// Holds the FSM encoding, iteration count and magnitude helper.
package alu_div_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } state_t;

  // One extra bit keeps |-2^31| exact.
  function automatic logic [WIDTH:0] mag33(
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH:0] e;
    e = {x[WIDTH-1], x};
    return x[WIDTH-1] ? -e : e;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor magnitude, restore on borrow.
module div_step #(
  parameter int WIDTH = alu_div_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH:0]   dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_in, bit_in};
    qbit    = shifted >= dvs;
    rem_out = qbit ? WIDTH'(shifted - dvs)
                   : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_32_seq.sv
// Sequential signed 32-bit divider, one quotient bit per clock.
// Quotient truncates toward zero; remainder follows the dividend sign.
module divider_32_seq #(
  parameter int WIDTH = alu_div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dne
);

  import alu_div_pkg::*;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH:0]   dvs;
  logic             qneg;
  logic             rneg;
  logic [WIDTH-1:0] rem_nxt;
  logic             qbit;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem),
    .bit_in (dvd[WIDTH-1]),
    .dvs    (dvs),
    .rem_out(rem_nxt),
    .qbit   (qbit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dne   <= 1'b0;
    end else if (ena) begin
      if (start) begin
        dvd   <= WIDTH'(mag33(a));
        dvs   <= mag33(b);
        // b=0 leaves the all-ones magnitude unnegated
        qneg  <= (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
        rneg  <= a[WIDTH-1];
        rem   <= '0;
        cnt   <= '0;
        dne   <= 1'b0;
        state <= BUSY;
      end else begin
        unique case (state)
          BUSY: begin
            rem <= rem_nxt;
            dvd <= {dvd[WIDTH-2:0], qbit};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ITER_COUNT - 1))
              state <= FIX;
          end
          FIX: begin
            q     <= qneg ? -dvd : dvd;
            r     <= rneg ? -rem : rem;
            dne   <= 1'b1;
            state <= DONE;
          end
          IDLE: ;
          DONE: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider_32_seq.sv
// Self-checking bench for divider_32_seq.
// Expected results are queued at start and popped on completion.
module tb_divider_32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] q;
  logic [31:0] r;
  logic        dne;

  int checks = 0;
  int errors = 0;

  logic [31:0] sq[$];
  logic [31:0] sr[$];

  divider_32_seq #(
    .WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .dne  (dne)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] eq,
    output logic [31:0] er
  );
    int sx;
    int sy;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = x;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      eq = 32'h8000_0000;
      er = 32'd0;
    end else begin
      eq = sx / sy;
      er = sx % sy;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_op(
    input logic [31:0] x,
    input logic [31:0] y,
    input bit          track
  );
    logic [31:0] eq;
    logic [31:0] er;
    if (track) begin
      model(x, y, eq, er);
      sq.push_back(eq);
      sr.push_back(er);
    end
    a = x;
    b = y;
    start = 1'b1;
    ena = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_dne(input int budget, output int n);
    n = 0;
    while (n < budget && dne !== 1'b1) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks += 3;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL reset_q: got %h expected %h", q, 32'd0);
    end
    if (r !== 32'd0) begin
      errors++;
      $display("FAIL reset_r: got %h expected %h", r, 32'd0);
    end
    if (dne !== 1'b0) begin
      errors++;
      $display("FAIL reset_dne: got %b expected 0", dne);
    end
    @(negedge clk);
    rst = 1'b1;
    ena = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    logic [31:0] eq;
    logic [31:0] er;
    start_op(32'd100, 32'd7, 1'b1);
    wait_dne(60, n);
    eq = sq.pop_front();
    er = sr.pop_front();
    checks += 3;
    if (n != 33) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 33", n);
    end
    if (q !== eq) begin
      errors++;
      $display("FAIL basic_q: got %0d expected %0d", $signed(q), $signed(eq));
    end
    if (r !== er) begin
      errors++;
      $display("FAIL basic_r: got %0d expected %0d", $signed(r), $signed(er));
    end
  endtask

  task automatic test_signs;
    logic [31:0] ta[3];
    logic [31:0] tb[3];
    int n;
    logic [31:0] eq;
    logic [31:0] er;
    ta = '{-32'sd100, 32'sd100, -32'sd100};
    tb = '{32'sd7, -32'sd7, -32'sd7};
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], 1'b1);
      wait_dne(60, n);
      eq = sq.pop_front();
      er = sr.pop_front();
      checks += 3;
      if (n != 33) begin
        errors++;
        $display("FAIL sign_latency[%0d]: got %0d expected 33", i, n);
      end
      if (q !== eq) begin
        errors++;
        $display("FAIL sign_q[%0d]: got %0d expected %0d",
                 i, $signed(q), $signed(eq));
      end
      if (r !== er) begin
        errors++;
        $display("FAIL sign_r[%0d]: got %0d expected %0d",
                 i, $signed(r), $signed(er));
      end
    end
  endtask

  task automatic test_bounds;
    logic [31:0] ta[4];
    logic [31:0] tb[4];
    int n;
    logic [31:0] eq;
    logic [31:0] er;
    ta = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd3, 32'd5};
    tb = '{32'hFFFF_FFFF, 32'd1, 32'd10, 32'd0};
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i], 1'b1);
      wait_dne(60, n);
      eq = sq.pop_front();
      er = sr.pop_front();
      checks += 3;
      if (n != 33) begin
        errors++;
        $display("FAIL bound_latency[%0d]: got %0d expected 33", i, n);
      end
      if (q !== eq) begin
        errors++;
        $display("FAIL bound_q[%0d]: got %h expected %h", i, q, eq);
      end
      if (r !== er) begin
        errors++;
        $display("FAIL bound_r[%0d]: got %h expected %h", i, r, er);
      end
    end
  endtask

  // Previous result is 5/0 -> q=-1, r=5; it must hold while busy.
  task automatic test_ena;
    int n;
    logic [31:0] eq;
    logic [31:0] er;
    start_op(32'd1000, 32'd3, 1'b1);
    repeat (10) @(negedge clk);
    ena = 1'b0;
    repeat (10) @(negedge clk);
    checks += 3;
    if (dne !== 1'b0) begin
      errors++;
      $display("FAIL ena_hold_dne: got %b expected 0", dne);
    end
    if (q !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL ena_hold_q: got %h expected %h", q, 32'hFFFF_FFFF);
    end
    if (r !== 32'd5) begin
      errors++;
      $display("FAIL ena_hold_r: got %h expected %h", r, 32'd5);
    end
    ena = 1'b1;
    wait_dne(60, n);
    eq = sq.pop_front();
    er = sr.pop_front();
    checks += 3;
    if (n + 10 != 33) begin
      errors++;
      $display("FAIL ena_latency: got %0d expected 33", n + 10);
    end
    if (q !== eq) begin
      errors++;
      $display("FAIL ena_q: got %0d expected %0d", q, eq);
    end
    if (r !== er) begin
      errors++;
      $display("FAIL ena_r: got %0d expected %0d", r, er);
    end
  endtask

  task automatic test_start_no_ena;
    ena = 1'b0;
    start = 1'b1;
    a = 32'd77;
    b = 32'd7;
    repeat (3) @(negedge clk);
    start = 1'b0;
    ena = 1'b1;
    repeat (40) @(negedge clk);
    checks += 3;
    if (dne !== 1'b1) begin
      errors++;
      $display("FAIL noena_dne: got %b expected 1", dne);
    end
    if (q !== 32'd333) begin
      errors++;
      $display("FAIL noena_q: got %0d expected 333", q);
    end
    if (r !== 32'd1) begin
      errors++;
      $display("FAIL noena_r: got %0d expected 1", r);
    end
  endtask

  task automatic test_reset_mid;
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_q: got %h expected 0", q);
    end
    if (r !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_r: got %h expected 0", r);
    end
    if (dne !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_dne: got %b expected 0", dne);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (dne !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: got dne=%b expected 0", dne);
    end
  endtask

  task automatic test_restart;
    int n;
    logic [31:0] eq;
    logic [31:0] er;
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (12) @(negedge clk);
    start_op(32'd50, 32'd5, 1'b1);
    wait_dne(60, n);
    eq = sq.pop_front();
    er = sr.pop_front();
    checks += 3;
    if (n != 33) begin
      errors++;
      $display("FAIL restart_latency: got %0d expected 33", n);
    end
    if (q !== eq) begin
      errors++;
      $display("FAIL restart_q: got %0d expected %0d", q, eq);
    end
    if (r !== er) begin
      errors++;
      $display("FAIL restart_r: got %0d expected %0d", r, er);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eq;
    logic [31:0] er;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      if (i % 3 == 0)
        y = 32'(int'($urandom_range(40)) - 20);
      else if (i % 3 == 1)
        y = 32'(int'($urandom_range(2000)) - 1000);
      else
        y = $urandom;
      if (i % 5 == 4)
        x = 32'(int'($urandom_range(200)) - 100);
      start_op(x, y, 1'b1);
      wait_dne(60, n);
      eq = sq.pop_front();
      er = sr.pop_front();
      checks += 3;
      if (n != 33) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: got %0d expected 33", i, n);
      end
      if (q !== eq) begin
        errors++;
        $display("FAIL b2b_q[%0d]: %h/%h got %h expected %h",
                 i, x, y, q, eq);
      end
      if (r !== er) begin
        errors++;
        $display("FAIL b2b_r[%0d]: %h%%%h got %h expected %h",
                 i, x, y, r, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_bounds();
    test_ena();
    test_start_no_ena();
    test_reset_mid();
    test_restart();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_32_seq.md
Name: divider_32_seq

Overview:
- Sequential 32-bit signed integer divider for the processor ALU. Produces quotient and remainder with Verilog `/` and `%` semantics.
- Iterative restoring algorithm, one quotient bit per clock, with a done flag.
- Sits beside the ALU's combinational units. The control path starts it, then polls `dne`.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is required to be supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- ena  in  1  clock enable; when 0 all internal state and outputs hold
- start  in  1  synchronous operation start; sampled only when ena=1
- a  in  32  dividend, two's complement
- b  in  32  divisor, two's complement
- q  out  32  quotient, two's complement, registered
- r  out  32  remainder, two's complement, registered
- dne  out  1  result valid, registered

Behaviour:
- Reset (rst=0, asynchronous): q=0, r=0, dne=0, state=IDLE, counter=0. Reset asserted mid-operation aborts the operation immediately.
- State machine:
  - IDLE: entered at reset.
  - LOAD: not a separate state; it happens on the start edge.
  - BUSY: 32 iteration cycles.
  - FIX: sign correction and output register write.
  - DONE: result held.
- Start edge (ena=1, start=1), taken from any state, including BUSY or FIX, which restarts and aborts the old operation:
  - latch |a| and |b|, the quotient sign (a[31]^b[31]) and the remainder sign (a[31]);
  - clear partial remainder and counter; dne<=0; go to BUSY;
  - q and r keep their previous values.
- BUSY, each ena=1 edge:
  - shift {partial remainder, dividend} left by 1;
  - trial-subtract the divisor magnitude; if non-negative, keep the difference and set quotient LSB to 1, else restore;
  - after the 32nd iteration go to FIX.
- FIX (one edge): negate the quotient if its sign bit is set; negate the remainder if the dividend was negative; write q and r; dne<=1; go to DONE.
- Latency: dne rises on the 33rd enabled rising edge after the start edge.
- DONE: q, r and dne hold until the next start edge or reset.
- ena=0: no state, counter or output change in any state. Latency counts enabled edges only.
- start=1 with ena=0 is ignored.
- Arithmetic rules:
  - Magnitudes use 33-bit internal arithmetic so that |-2^31| is exact.
  - Quotient truncates toward zero; the remainder carries the sign of the dividend; a = q*b + r.
- Divide by zero (b=0): q=32'hFFFFFFFF, r=a. Same latency, dne asserted normally.
- Overflow (-2147483648 / -1): q=-2147483648 (wraps), r=0.
- a and b are not required to stay stable after the start edge.

Decomposition:
- Shared package alu_div_pkg holds:
  - WIDTH=32;
  - the state enum {IDLE, BUSY, FIX, DONE};
  - ITER_COUNT=32 and a 6-bit counter width.
- One combinational sub-module, div_step: one restoring step. Inputs are the partial remainder, next dividend bit and divisor magnitude; outputs are the new partial remainder and the quotient bit.
- The top level holds the registers, FSM, magnitude conversion and sign fix.

Test Plan:
- 100 / 7 -> q=14, r=2. dne=0 from the start edge until it rises on the 33rd enabled edge.
- Sign cases:
  - -100 / 7 -> q=-14, r=-2
  - 100 / -7 -> q=-14, r=2
  - -100 / -7 -> q=14, r=-2
- Boundaries:
  - -2147483648 / -1 -> q=-2147483648, r=0
  - 2147483647 / 1 -> q=2147483647, r=0
  - 5 / 0 -> q=-1, r=5
  - 3 / 10 -> q=0, r=3
- ena handling:
  - 1000 / 3 with ena=0 held for 10 cycles mid-BUSY -> dne still rises on the 33rd enabled edge; q=333, r=1.
  - start with ena=0 -> nothing changes.
- Reset and restart:
  - rst=0 pulse mid-BUSY -> q=0, r=0, dne=0 immediately, without a clock edge.
  - start asserted again mid-BUSY with 50 / 5 -> q=10, r=0, 33 enabled edges after the restart.
  - Back-to-back random signed vectors -> q and r match a/b and a%b.
